// File: rtl/ret_pred_checker_pkg.sv
// Shared types and helpers for the return-prediction checker.
// Provides fallback ISA widths when the shared isa.v definitions are not already in scope.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RAS_SIZE
`define RAS_SIZE 8
`endif
`ifndef RAS_PTR_WIDTH
`define RAS_PTR_WIDTH 3
`endif

package ret_pred_checker_pkg;

   // One in-flight prediction: the popped target and the RAS pointer after the pop.
   typedef struct packed {
      logic [`XLEN-1:0]          target;
      logic [`RAS_PTR_WIDTH-1:0] ptr;
   } ras_entry_t;

   localparam int RAS_ENTRY_W = $bits(ras_entry_t);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ret_pred_fifo.sv
// Circular FIFO of in-flight return predictions; clear has priority over push and pop.
module ret_pred_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   always_comb begin
      full    = (cnt_q == CW'(DEPTH));
      empty   = (cnt_q == '0);
      do_push = push && !full && !clear;
      do_pop  = pop && !empty && !clear;
      rdata   = mem[rp_q];
      count   = cnt_q;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (clear) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp_q] <= wdata;
   end

endmodule

// File: rtl/ret_pred_checker.sv
// Checks RAS return predictions against resolved JALR targets and requests redirect/RAS restore.
// Optional RET_CHK_PERF_EN adds saturating hit_cnt/miss_cnt outputs.
module ret_pred_checker
   import ret_pred_checker_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      pred_valid,
   input  logic [`XLEN-1:0]          pred_target,
   input  logic [`RAS_PTR_WIDTH-1:0] pred_ptr,
   output logic                      pred_ready,
   input  logic                      res_valid,
   input  logic [`XLEN-1:0]          res_target,
   output logic                      mispredict,
   output logic [`XLEN-1:0]          redirect_pc,
   output logic                      ras_restore_en,
   output logic [`RAS_PTR_WIDTH-1:0] ras_restore_ptr,
   output logic                      orphan,
   output logic [$clog2(DEPTH):0]    inflight_count,
`ifdef RET_CHK_PERF_EN
   output logic [31:0]               hit_cnt,
   output logic [31:0]               miss_cnt,
`endif
   output logic                      dbg_state
);

   // Handshake: a prediction is taken on a rising edge when pred_valid && pred_ready;
   // pred_ready depends only on state and occupancy, never on pred_valid.
   typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

   state_t     state_q, state_d;
   ras_entry_t wr_entry, head;
   logic       run, full, empty, push, pop, clear, hit, mismatch, orphan_ev;

   always_comb begin
      run        = (state_q == RUN);
      pred_ready = run && !full;
      push       = pred_valid && pred_ready && !flush;
      pop        = run && !flush && res_valid && !empty;
      mismatch   = pop && (res_target != head.target);
      hit        = pop && !mismatch;
      orphan_ev  = run && !flush && res_valid && empty;
      clear      = (run && flush) || mismatch;
      wr_entry   = '{target: pred_target, ptr: pred_ptr};
      dbg_state  = state_q;
   end

   ret_pred_fifo #(
      .DEPTH (DEPTH),
      .W     (RAS_ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (inflight_count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (!flush && (mismatch || orphan_ev)) state_d = RECOVER;
         RECOVER: if (flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Redirect fields only update on an event, so they stay stable around the pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mispredict      <= 1'b0;
         orphan          <= 1'b0;
         ras_restore_en  <= 1'b0;
         redirect_pc     <= '0;
         ras_restore_ptr <= '0;
      end else begin
         mispredict     <= mismatch || orphan_ev;
         orphan         <= orphan_ev;
         ras_restore_en <= mismatch;
         if (mismatch || orphan_ev) redirect_pc <= res_target;
         if (mismatch) ras_restore_ptr <= head.ptr;
      end
   end

`ifdef RET_CHK_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit) hit_cnt <= sat_inc(hit_cnt);
         if (mismatch || orphan_ev) miss_cnt <= sat_inc(miss_cnt);
      end
   end
`else
   logic unused_hit;
   assign unused_hit = hit;
`endif

endmodule

// File: tb/tb_ret_pred_checker.sv
// Directed bench for ret_pred_checker: vector table plus reset/counter sequences.
module tb_ret_pred_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush, pred_valid, res_valid;
   logic [31:0] pred_target, res_target;
   logic [2:0]  pred_ptr;
   logic        pred_ready, mispredict, ras_restore_en, orphan, dbg_state;
   logic [31:0] redirect_pc;
   logic [2:0]  ras_restore_ptr;
   logic [2:0]  inflight_count;
`ifdef RET_CHK_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        flush, pv;
      logic [31:0] pt;
      logic [2:0]  pp;
      logic        rv;
      logic [31:0] rt;
      logic        e_ready, e_mis, e_orph, e_ren;
      logic [31:0] e_rpc;
      logic [2:0]  e_rptr;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   ret_pred_checker #(.DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .pred_valid      (pred_valid),
      .pred_target     (pred_target),
      .pred_ptr        (pred_ptr),
      .pred_ready      (pred_ready),
      .res_valid       (res_valid),
      .res_target      (res_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .ras_restore_en  (ras_restore_en),
      .ras_restore_ptr (ras_restore_ptr),
      .orphan          (orphan),
      .inflight_count  (inflight_count),
`ifdef RET_CHK_PERF_EN
      .hit_cnt         (hit_cnt),
      .miss_cnt        (miss_cnt),
`endif
      .dbg_state       (dbg_state)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic fl, input logic pv, input logic [31:0] pt, input logic [2:0] pp,
                      input logic rv, input logic [31:0] rt, input logic e_ready, input logic e_mis,
                      input logic e_orph, input logic e_ren, input logic [31:0] e_rpc,
                      input logic [2:0] e_rptr, input logic [2:0] e_cnt);
      vec_t v;
      v.flush = fl; v.pv = pv; v.pt = pt; v.pp = pp; v.rv = rv; v.rt = rt;
      v.e_ready = e_ready; v.e_mis = e_mis; v.e_orph = e_orph; v.e_ren = e_ren;
      v.e_rpc = e_rpc; v.e_rptr = e_rptr; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   // Drive one cycle of inputs, let the edge pass, then compare outputs.
   task automatic apply(input vec_t v, input int idx);
      flush = v.flush; pred_valid = v.pv; pred_target = v.pt; pred_ptr = v.pp;
      res_valid = v.rv; res_target = v.rt;
      @(posedge clk);
      #1;
      flush = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
      chk("pred_ready", idx, 32'(pred_ready), 32'(v.e_ready));
      chk("mispredict", idx, 32'(mispredict), 32'(v.e_mis));
      chk("orphan", idx, 32'(orphan), 32'(v.e_orph));
      chk("ras_restore_en", idx, 32'(ras_restore_en), 32'(v.e_ren));
      chk("inflight_count", idx, 32'(inflight_count), 32'(v.e_cnt));
      if (v.e_mis) chk("redirect_pc", idx, redirect_pc, v.e_rpc);
      if (v.e_ren) chk("ras_restore_ptr", idx, 32'(ras_restore_ptr), 32'(v.e_rptr));
   endtask

   task automatic push_res(input logic [31:0] pt, input logic [2:0] pp, input logic [31:0] rt,
                           input int idx, input logic e_mis);
      vec_t v;
      v = '{flush: 0, pv: 1, pt: pt, pp: pp, rv: 0, rt: 0, e_ready: 1, e_mis: 0, e_orph: 0,
            e_ren: 0, e_rpc: 0, e_rptr: 0, e_cnt: 1};
      apply(v, idx);
      v = '{flush: 0, pv: 0, pt: 0, pp: 0, rv: 1, rt: rt, e_ready: !e_mis, e_mis: e_mis, e_orph: 0,
            e_ren: e_mis, e_rpc: rt, e_rptr: pp, e_cnt: 0};
      apply(v, idx + 1);
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; flush = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
      pred_target = '0; res_target = '0; pred_ptr = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_ready", 0, 32'(pred_ready), 32'd1);
      chk("reset_mispredict", 0, 32'(mispredict), 32'd0);
      chk("reset_count", 0, 32'(inflight_count), 32'd0);
      chk("reset_redirect_pc", 0, redirect_pc, 32'd0);

      //   fl pv pt           pp rv rt           rdy mis orp ren rpc          rptr cnt
      add(0, 1, 32'h1004,    2, 0, 0,           1,  0,  0,  0,  0,           0,   1); // match
      add(0, 0, 0,           0, 1, 32'h1004,    1,  0,  0,  0,  0,           0,   0);
      add(0, 1, 32'h1004,    2, 0, 0,           1,  0,  0,  0,  0,           0,   1); // mismatch
      add(0, 1, 32'h2008,    1, 0, 0,           1,  0,  0,  0,  0,           0,   2);
      add(0, 0, 0,           0, 1, 32'h3000,    0,  1,  0,  1,  32'h3000,    2,   0);
      add(0, 1, 32'h5000,    4, 1, 32'h9999,    0,  0,  0,  0,  0,           0,   0); // ignored in RECOVER
      add(1, 0, 0,           0, 0, 0,           1,  0,  0,  0,  0,           0,   0);
      add(0, 0, 0,           0, 1, 32'h4000,    0,  1,  1,  0,  32'h4000,    0,   0); // orphan
      add(1, 0, 0,           0, 0, 0,           1,  0,  0,  0,  0,           0,   0);
      add(0, 1, 32'h100,     0, 0, 0,           1,  0,  0,  0,  0,           0,   1); // fill
      add(0, 1, 32'h200,     1, 0, 0,           1,  0,  0,  0,  0,           0,   2);
      add(0, 1, 32'h300,     2, 0, 0,           1,  0,  0,  0,  0,           0,   3);
      add(0, 1, 32'h400,     3, 0, 0,           0,  0,  0,  0,  0,           0,   4);
      add(0, 1, 32'h500,     4, 0, 0,           0,  0,  0,  0,  0,           0,   4); // dropped
      add(0, 1, 32'h600,     5, 1, 32'h100,     1,  0,  0,  0,  0,           0,   3); // no pass-through
      add(0, 1, 32'h600,     5, 0, 0,           0,  0,  0,  0,  0,           0,   4);
      add(0, 0, 0,           0, 1, 32'h200,     1,  0,  0,  0,  0,           0,   3); // drain, wrap
      add(0, 0, 0,           0, 1, 32'h300,     1,  0,  0,  0,  0,           0,   2);
      add(0, 0, 0,           0, 1, 32'h400,     1,  0,  0,  0,  0,           0,   1);
      add(0, 0, 0,           0, 1, 32'h600,     1,  0,  0,  0,  0,           0,   0);
      add(0, 1, 32'h700,     6, 0, 0,           1,  0,  0,  0,  0,           0,   1); // flush in RUN
      add(1, 1, 32'h800,     7, 1, 32'h123,     1,  0,  0,  0,  0,           0,   0);
      add(0, 1, 32'hA,       1, 0, 0,           1,  0,  0,  0,  0,           0,   1); // push+pop
      add(0, 1, 32'hB,       2, 1, 32'hA,       1,  0,  0,  0,  0,           0,   1);
      add(0, 0, 0,           0, 1, 32'hB,       1,  0,  0,  0,  0,           0,   0);

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

`ifdef RET_CHK_PERF_EN
      chk("hit_cnt_table", 100, hit_cnt, 32'd8);
      chk("miss_cnt_table", 100, miss_cnt, 32'd2);
`endif

      // Reset asserted mid-RECOVER, away from any clock edge.
      push_res(32'h10, 3'd3, 32'h20, 200, 1'b1);
      chk("recover_state", 201, 32'(dbg_state), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mispredict", 202, 32'(mispredict), 32'd0);
      chk("rst_restore_en", 202, 32'(ras_restore_en), 32'd0);
      chk("rst_redirect_pc", 202, redirect_pc, 32'd0);
      chk("rst_restore_ptr", 202, 32'(ras_restore_ptr), 32'd0);
      chk("rst_orphan", 202, 32'(orphan), 32'd0);
      chk("rst_count", 202, 32'(inflight_count), 32'd0);
      chk("rst_state", 202, 32'(dbg_state), 32'd0);
      @(posedge clk);
      #3 reset = 1'b0;
      v = '{flush: 0, pv: 0, pt: 0, pp: 0, rv: 0, rt: 0, e_ready: 1, e_mis: 0, e_orph: 0,
            e_ren: 0, e_rpc: 0, e_rptr: 0, e_cnt: 0};
      apply(v, 203);

      // Three matches and one mismatch from a clean reset.
      push_res(32'h1000, 3'd1, 32'h1000, 300, 1'b0);
      push_res(32'h2000, 3'd2, 32'h2000, 302, 1'b0);
      push_res(32'h3000, 3'd3, 32'h3000, 304, 1'b0);
      push_res(32'h4000, 3'd4, 32'h4444, 306, 1'b1);
      v = '{flush: 1, pv: 0, pt: 0, pp: 0, rv: 0, rt: 0, e_ready: 1, e_mis: 0, e_orph: 0,
            e_ren: 0, e_rpc: 0, e_rptr: 0, e_cnt: 0};
      apply(v, 308);
`ifdef RET_CHK_PERF_EN
      chk("hit_cnt", 309, hit_cnt, 32'd3);
      chk("miss_cnt", 309, miss_cnt, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ret_pred_checker.md
RET_PRED_CHECKER -- requirements
Module: ret_pred_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the in-flight prediction FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  pipeline flush; it also acknowledges a redirect.
REQ-005 SHALL have port pred_valid  input  1  fetch popped the return-address stack for a return prediction.
REQ-006 SHALL have port pred_target  input  `XLEN  predicted return address, the popped top of stack.
REQ-007 SHALL have port pred_ptr  input  `RAS_PTR_WIDTH  return-address-stack pointer value after that pop.
REQ-008 SHALL have port pred_ready  output  1  the FIFO accepts a prediction this cycle.
REQ-009 SHALL have port res_valid  input  1  EX resolved a return JALR.
REQ-010 SHALL have port res_target  input  `XLEN  actual computed JALR target.
REQ-011 SHALL have port mispredict  output  1  one-cycle redirect pulse.
REQ-012 SHALL have port redirect_pc  output  `XLEN  correct fetch address, valid while mispredict is high.
REQ-013 SHALL have port ras_restore_en  output  1  write ras_restore_ptr into the stack pointer, same cycle as mispredict.
REQ-014 SHALL have port ras_restore_ptr  output  `RAS_PTR_WIDTH  pointer value to restore.
REQ-015 SHALL have port orphan  output  1  one-cycle pulse when a return resolves with no prediction outstanding.
REQ-016 SHALL have port inflight_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL enqueue {pred_target, pred_ptr} when pred_valid && pred_ready; pred_ready = (state==RUN) && !full, with no pass-through when full.
REQ-018 SHALL, on res_valid with the FIFO non-empty, dequeue the head and compare res_target with head target on all `XLEN bits.
REQ-019 SHALL, on a match, raise no outputs; enqueue and dequeue in the same cycle keep the count unchanged.
REQ-020 SHALL, on a mismatch, in the next cycle register these outputs: mispredict=1, redirect_pc=res_target, ras_restore_en=1, ras_restore_ptr=head ptr.
REQ-021 SHALL, on the same mismatch, clear the FIFO and enter RECOVER.
REQ-022 SHALL, on res_valid with the FIFO empty, in the next cycle pulse orphan=1 and mispredict=1 with redirect_pc=res_target and ras_restore_en=0, then enter RECOVER.
REQ-023 SHALL have exactly two states: RUN and RECOVER.
REQ-024 SHALL hold pred_ready=0 in RECOVER and ignore pred_valid and res_valid there.
REQ-025 SHALL leave RECOVER to RUN on the first cycle flush=1; RUN is effective the following cycle.
REQ-026 SHALL, on flush in RUN, clear the FIFO and discard any same-cycle res_valid and pred_valid.
REQ-027 SHALL wrap read and write pointers modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-028 SHALL hold mispredict, orphan and ras_restore_en for exactly one cycle per event.

Reset
REQ-029 SHALL, on reset assertion and at any point mid-operation, immediately force: state=RUN, FIFO empty, inflight_count=0, mispredict=0, orphan=0, ras_restore_en=0, redirect_pc=0, ras_restore_ptr=0.
REQ-030 SHALL drive pred_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, with RET_CHK_PERF_EN defined, add 32-bit outputs hit_cnt and miss_cnt.
REQ-032 SHALL increment hit_cnt on a match, and miss_cnt on a mismatch or orphan.
REQ-033 SHALL saturate both counters at 0xFFFFFFFF and reset them to 0.
REQ-034 SHALL, without RET_CHK_PERF_EN, have neither these ports nor these counters.

Structure
REQ-035 SHALL take `XLEN, `RAS_PTR_WIDTH and `RAS_SIZE from the shared isa.v definitions.
REQ-036 SHALL define the RUN/RECOVER state encodings as constants local to the module.
REQ-037 SHALL implement the prediction FIFO as one sub-module ret_pred_fifo, parameterised by DEPTH and entry width.

Verification
REQ-038 SHALL cover a match: push target 0x0000_1004 ptr 2, then res 0x0000_1004 -> no mispredict, inflight_count 1->0.
REQ-039 SHALL cover a mismatch: push 0x1004/ptr 2 and 0x2008/ptr 1, then res 0x3000 -> next cycle mispredict=1, redirect_pc=0x3000, restore ptr=2, count=0, pred_ready=0 until flush.
REQ-040 SHALL cover an orphan: res 0x4000 with the FIFO empty -> orphan=1, mispredict=1, ras_restore_en=0, redirect_pc=0x4000.
REQ-041 SHALL cover full: 4 pushes -> pred_ready=0; a 5th pred_valid is dropped; a matching res with a simultaneous push leaves count=4 only after pred_ready rises the next cycle.
REQ-042 SHALL cover reset mid-RECOVER: reset -> all outputs per REQ-029 at once; pred_ready=1 after release.
REQ-043 SHALL cover the counters with RET_CHK_PERF_EN: 3 matches and 1 mismatch -> hit_cnt=3, miss_cnt=1.
